// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared constants and types for the multicycle CPU control path:
//             opcodes, PC-source / ALU-select encodings and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // PC mux select, shared with the datapath mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPE   = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm_if
//  Purpose  : Control/status bundle between the main control FSM (master)
//             and the multicycle datapath plus memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;

  // status into the controller
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;

  // controls out of the controller
  logic [1:0] PCSource;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       Fault;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCSource, PCEn, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Fault
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCSource, PCEn, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Fault
  );

endinterface
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_wait_timer
//  Purpose  : Counts consecutive stall cycles of a memory handshake and flags
//             the cycle on which the stall budget is exhausted.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
  parameter int LIMIT = 16,
  parameter int W     = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clear,    // not in a waiting state: hold at zero
  input  wire logic         stall,    // request outstanding this cycle
  output logic              timeout
);

  localparam logic [W-1:0] C_LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  // Count stalled cycles; any non-stall cycle or clear returns to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (clear || !stall)
      r_count <= '0;
    else
      r_count <= r_count + 1'b1;
  end

  // The LIMIT-th stalled cycle is the last one allowed; a response that
  // arrives on that same cycle still completes the access.
  assign timeout = !clear && stall && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm
//  Purpose  : Main control FSM of the multicycle CPU: sequences fetch,
//             decode, execute, memory and writeback, with a watchdog that
//             traps an unresponsive memory and a sticky fault flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mc_control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_fault;
  logic       r_is_bne;
  logic       w_in_mem;
  logic       w_timeout;

  logic [1:0] w_pc_source;
  logic       w_pc_en;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);

  mc_wait_timer #(
    .LIMIT (WAIT_LIMIT),
    .W     (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_in_mem),
    .stall   (!bus.MemReady),
    .timeout (w_timeout)
  );

  // State register, sticky fault, and the beq/bne flavour captured in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_fault  <= 1'b0;
      r_is_bne <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == S_TRAP)
        r_fault <= 1'b1;
      if (r_state == S_DECODE)
        r_is_bne <= (bus.Opcode == OP_BNE);
    end
  end

  // Next-state and control decode from the current state
  always_comb begin
    w_state_next = r_state;
    w_pc_source  = PCSRC_ALU;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_alu_op     = ALUOP_ADD;

    case (r_state)
      S_RESET: w_state_next = S_FETCH;

      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (bus.MemReady) begin
          w_ir_write   = 1'b1;
          w_pc_en      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        w_alu_src_b = SRCB_SHIMM;
        case (bus.Opcode)
          OP_LW, OP_SW:   w_state_next = S_MEMADR;
          OP_RTYPE:       w_state_next = S_RTYPE;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          OP_ADDI:        w_state_next = S_ADDIEX;
          OP_J:           w_state_next = S_JUMP;
          default:        w_state_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_state_next = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.MemReady)
          w_state_next = S_MEMWB;
        else if (w_timeout)
          w_state_next = S_TRAP;
      end

      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.MemReady)
          w_state_next = S_FETCH;
        else if (w_timeout)
          w_state_next = S_TRAP;
      end

      S_RTYPE: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_SUB;
        w_pc_source  = PCSRC_ALUOUT;
        w_pc_en      = r_is_bne ? !bus.Zero : bus.Zero;
        w_state_next = S_FETCH;
      end

      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_state_next = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end

      S_JUMP: begin
        w_pc_source  = PCSRC_JUMP;
        w_pc_en      = 1'b1;
        w_state_next = S_FETCH;
      end

      S_TRAP: w_state_next = S_TRAP;

      default: w_state_next = S_RESET;
    endcase
  end

  assign bus.PCSource = w_pc_source;
  assign bus.PCEn     = w_pc_en;
  assign bus.IorD     = w_iord;
  assign bus.MemRead  = w_mem_read;
  assign bus.MemWrite = w_mem_write;
  assign bus.IRWrite  = w_ir_write;
  assign bus.RegDst   = w_reg_dst;
  assign bus.MemtoReg = w_mem_to_reg;
  assign bus.RegWrite = w_reg_write;
  assign bus.ALUSrcA  = w_alu_src_a;
  assign bus.ALUSrcB  = w_alu_src_b;
  assign bus.ALUOp    = w_alu_op;
  assign bus.Fault    = r_fault;

endmodule
`default_nettype wire
